mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter placed in front of a single `mem_system` instance, so instruction fetch and data load/store share one cached memory.
- It grants the memory to one port at a time and holds the downstream `Rd`/`Wr` request stable until `Done`.
- It returns the read data and a one-cycle done pulse to the granted port.
- It bounds instruction-port starvation with a data-grant streak counter.

## Interface
Parameters:
- `MAX_DATA_STREAK`, default 2: maximum consecutive data grants while an instruction request waits. Legal range is 1–3.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_rd`  in  1  instruction read request; held until `i_done`.
- `i_addr`  in  16  instruction address; stable while `i_rd`.
- `i_data`  out  16  instruction read data; valid when `i_done`.
- `i_done`  out  1  one-cycle completion pulse.
- `i_stall`  out  1  `i_rd & ~i_done`.
- `d_rd`, `d_wr`  in  1 each  data read / write request; held until `d_done`.
- `d_addr`  in  16  data address.
- `d_wdata`  in  16  data write value.
- `d_rdata`  out  16  data read value; valid when `d_done` follows a read.
- `d_done`  out  1  one-cycle completion pulse.
- `d_stall`  out  1  `(d_rd | d_wr) & ~d_done`.
- `m_addr`, `m_wdata`  out  16 each  to `mem_system` `Addr`, `DataIn`.
- `m_rd`, `m_wr`  out  1 each  to `mem_system` `Rd`, `Wr`.
- `m_rdata`  in  16  from `mem_system` `DataOut`.
- `m_done`  in  1  from `mem_system` `Done`.
- `m_err`  in  1  from `mem_system` `err`.
- `err`  out  1  sticky error flag.

## Operation
States and transitions:
- **IDLE**: drive `m_rd = m_wr = 0`.
  - Data request pending and streak < `MAX_DATA_STREAK` (or no `i_rd`) → GNT_D.
  - Else `i_rd` → GNT_I.
  - Else stay in IDLE.
- **GNT_I**: `m_addr = i_addr`, `m_rd = 1`, `m_wr = 0`; `m_wdata` = 0.
  - Stay until `m_done`.
  - On `m_done`: latch `m_rdata` into `i_data`, then → RESP_I.
- **GNT_D**: `m_addr = d_addr`, `m_rd = d_rd`, `m_wr = d_wr`, `m_wdata = d_wdata`.
  - Stay until `m_done`.
  - On `m_done`: latch `m_rdata` into `d_rdata` (read only; on a write `d_rdata` holds its previous value), then → RESP_D.
- **RESP_I / RESP_D**: assert `i_done` or `d_done` for exactly this cycle; `m_rd = m_wr = 0`; → IDLE.
- **ERR**: all `m_*` strobes 0, `err = 1`, no done pulses. Exit only via `rst`.

Streak counter (2-bit, saturating at `MAX_DATA_STREAK`):
- Increments on IDLE→GNT_D when `i_rd = 1`.
- Clears on IDLE→GNT_I.
- Clears on IDLE→GNT_D when `i_rd = 0`.

Error entry (→ ERR from any state):
- `d_rd & d_wr` sampled in IDLE.
- `m_err = 1` in any state.
- `m_done` seen in IDLE or RESP_*.

Request ownership and latching:
- A granted request is never preempted.
- A requester dropping its request mid-grant is illegal. The arbiter ignores the drop and keeps the latched direction.
- Direction (`rd`/`wr`) and owner are registered at grant. Address and write data pass through from the owner.

Reset:
- All outputs 0, state IDLE, streak 0, `i_data = d_rdata = 0`, `err = 0`.
- Assertion mid-grant aborts immediately. The downstream `mem_system` is reset by the same `rst`.

## Timing
- Grant latency: a request seen in IDLE at edge N drives `m_rd`/`m_wr` during cycle N+1.
- Completion latency: `m_done` in cycle K → `x_done` and data valid in cycle K+1, then IDLE at K+2.
- Minimum turnaround between grants: 2 cycles (RESP + IDLE).
- `i_stall` and `d_stall` are combinational from the request inputs and the registered done flags.
- `m_rd`/`m_wr` stay continuously high from the grant cycle through the `m_done` cycle, with no glitches.
- Simultaneous `i_rd` and `d_rd` in IDLE with streak 0: data wins.

## Test plan
- Lone instruction read: `i_addr = 0x0040`, `m_done` 3 cycles after grant with `m_rdata = 0xBEEF` → `i_done` one cycle later, `i_data = 0xBEEF`, `d_done` never asserted.
- Data write: `d_wr = 1`, `d_addr = 0x1234`, `d_wdata = 0x5A5A` → `m_wr = 1`, `m_wdata = 0x5A5A` held until `m_done`; `d_done` pulses once; `d_rdata` unchanged.
- Contention with `MAX_DATA_STREAK = 2`: `i_rd` and `d_rd` held continuously → grant order D, D, I, D, D, I.
- `d_rd = d_wr = 1` in IDLE → `err = 1` next cycle, all `m_*` strobes 0 thereafter, `err` remains set until `rst`.
- `m_err` pulse during GNT_I → ERR; no `i_done` is produced.
- `rst` asserted asynchronously mid-GNT_D → `m_rd`, `m_wr`, `d_done`, and `err` all 0 before the next edge; after release, a new `i_rd` is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one mem_system port.
// Data has priority, bounded by a streak counter so a waiting fetch is never starved.
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [15:0] m_rdata,
  input  logic        m_done,
  input  logic        m_err,
  output logic        err,
  output logic [2:0]  state_dbg
);

  // Handshake: a requester raises x_rd/x_wr and holds it (with address and
  // data stable) until it sees x_done high for one cycle; downstream m_rd/m_wr
  // stay high from the grant cycle until the cycle m_done is seen.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT_I  = 3'd1,
    GNT_D  = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [1:0] STREAK_MAX = 2'(MAX_DATA_STREAK);

  state_t      state, state_nxt;
  logic [1:0]  streak, streak_nxt;
  logic        lat_rd, lat_wr, lat_rd_nxt, lat_wr_nxt;
  logic [15:0] i_data_nxt, d_rdata_nxt;
  logic        d_pend;
  logic        err_entry;

  assign d_pend = d_rd | d_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      streak  <= 2'd0;
      lat_rd  <= 1'b0;
      lat_wr  <= 1'b0;
      i_data  <= 16'h0000;
      d_rdata <= 16'h0000;
    end else begin
      state   <= state_nxt;
      streak  <= streak_nxt;
      lat_rd  <= lat_rd_nxt;
      lat_wr  <= lat_wr_nxt;
      i_data  <= i_data_nxt;
      d_rdata <= d_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    streak_nxt  = streak;
    lat_rd_nxt  = lat_rd;
    lat_wr_nxt  = lat_wr;
    i_data_nxt  = i_data;
    d_rdata_nxt = d_rdata;
    m_addr      = 16'h0000;
    m_wdata     = 16'h0000;
    m_rd        = 1'b0;
    m_wr        = 1'b0;
    err_entry   = m_err;

    case (state)
      IDLE: begin
        if (d_rd && d_wr) begin
          err_entry = 1'b1;
        end else if (d_pend && (streak < STREAK_MAX || !i_rd)) begin
          state_nxt  = GNT_D;
          lat_rd_nxt = d_rd;
          lat_wr_nxt = d_wr;
          // Only grants taken while a fetch is waiting count against it.
          if (!i_rd)
            streak_nxt = 2'd0;
          else if (streak < STREAK_MAX)
            streak_nxt = streak + 2'd1;
        end else if (i_rd) begin
          state_nxt  = GNT_I;
          streak_nxt = 2'd0;
        end
        if (m_done) err_entry = 1'b1;
      end
      GNT_I: begin
        m_addr = i_addr;
        m_rd   = 1'b1;
        if (m_done) begin
          i_data_nxt = m_rdata;
          state_nxt  = RESP_I;
        end
      end
      GNT_D: begin
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_rd    = lat_rd;
        m_wr    = lat_wr;
        if (m_done) begin
          if (lat_rd) d_rdata_nxt = m_rdata;
          state_nxt = RESP_D;
        end
      end
      RESP_I, RESP_D: begin
        state_nxt = IDLE;
        if (m_done) err_entry = 1'b1;
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = ERR;
      end
    endcase

    // A failing access must not leave partially returned data behind.
    if (err_entry) begin
      state_nxt   = ERR;
      i_data_nxt  = i_data;
      d_rdata_nxt = d_rdata;
    end
  end

  assign i_done    = (state == RESP_I);
  assign d_done    = (state == RESP_D);
  assign err       = (state == ERR);
  assign i_stall   = i_rd & ~i_done;
  assign d_stall   = d_pend & ~d_done;
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// concurrent traffic against a memory model and a grant-order reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int MAX_STREAK = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd;
  logic [15:0] i_addr;
  logic [15:0] i_data;
  logic        i_done, i_stall;
  logic        d_rd, d_wr;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        d_done, d_stall;
  logic [15:0] m_addr, m_wdata, m_rdata;
  logic        m_rd, m_wr, m_done, m_err;
  logic        err;
  logic [2:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  bit resp_en;
  bit resp_rand;
  int resp_lat;

  logic [15:0] sim_mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] exp_d_rdata;
  logic [0:0]  exp_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DATA_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst(rst),
    .i_rd(i_rd), .i_addr(i_addr), .i_data(i_data), .i_done(i_done), .i_stall(i_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .d_stall(d_stall),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_rdata(m_rdata), .m_done(m_done), .m_err(m_err), .err(err), .state_dbg(state_dbg)
  );

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] ref_lookup(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // mem_system stand-in: answers a held strobe after a chosen number of cycles.
  initial begin : responder
    int cnt;
    int lat;
    cnt = 0;
    lat = 0;
    m_done = 1'b0;
    m_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      if (resp_en && !rst && (m_rd || m_wr)) begin
        if (cnt == 0) lat = resp_rand ? int'($urandom_range(0, 4)) : resp_lat;
        if (cnt >= lat) begin
          cnt = 0;
          m_done = 1'b1;
          if (m_wr) sim_mem[m_addr] = m_wdata;
          else m_rdata = sim_mem.exists(m_addr) ? sim_mem[m_addr] : init_val(m_addr);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    i_rd = 1'b0; i_addr = 16'h0000;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    m_err = 1'b0;
    exp_d_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_rd = 1'b0; i_addr = 16'h0000;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    m_err = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_rd, m_wr, i_done, d_done, err, i_stall, d_stall} !== 7'b0) begin
      failures++;
      $display("FAIL reset_strobes: got %b expected 0000000",
               {m_rd, m_wr, i_done, d_done, err, i_stall, d_stall});
    end
    checks++;
    if (i_data !== 16'h0000) begin
      failures++; $display("FAIL reset_i_data: got %h expected 0000", i_data);
    end
    checks++;
    if (d_rdata !== 16'h0000) begin
      failures++; $display("FAIL reset_d_rdata: got %h expected 0000", d_rdata);
    end
    checks++;
    if ({m_addr, m_wdata} !== 32'h0) begin
      failures++; $display("FAIL reset_m_bus: got %h expected 00000000", {m_addr, m_wdata});
    end
    rst = 1'b0;
    exp_d_rdata = 16'h0000;
    @(negedge clk);
  endtask

  task automatic test_instr_read();
    int n;
    int d_seen;
    bit first_rd;
    bit gap;
    sim_mem[16'h0040] = 16'hBEEF;
    ref_mem[16'h0040] = 16'hBEEF;
    resp_en = 1'b1; resp_rand = 1'b0; resp_lat = 3;
    n = 0; d_seen = 0; first_rd = 1'b0; gap = 1'b0;
    i_addr = 16'h0040; i_rd = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (d_done) d_seen++;
      if (i_done) begin n = c; break; end
      if (c == 1) first_rd = m_rd;
      if (!m_rd || m_wr || m_addr !== 16'h0040 || !i_stall) gap = 1'b1;
    end
    i_rd = 1'b0;
    checks++;
    if (n != 5) begin
      failures++; $display("FAIL instr_done_latency: got cycle %0d expected 5", n);
    end
    checks++;
    if (first_rd !== 1'b1) begin
      failures++; $display("FAIL instr_grant_latency: m_rd=%b expected 1", first_rd);
    end
    checks++;
    if (gap) begin
      failures++; $display("FAIL instr_strobe_hold: strobe dropped got 1 expected 0");
    end
    checks++;
    if (i_data !== 16'hBEEF) begin
      failures++; $display("FAIL instr_data: got %h expected beef", i_data);
    end
    repeat (3) begin
      @(negedge clk);
      if (d_done || i_done) d_seen++;
    end
    checks++;
    if (d_seen != 0) begin
      failures++; $display("FAIL instr_no_extra_done: got %0d expected 0", d_seen);
    end
  endtask

  task automatic test_data_write();
    int n;
    int wr_hi;
    int pulses;
    bit bad;
    resp_en = 1'b1; resp_rand = 1'b0; resp_lat = 2;
    n = 0; wr_hi = 0; pulses = 0; bad = 1'b0;
    d_addr = 16'h1234; d_wdata = 16'h5A5A; d_wr = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (d_done) begin n = c; pulses++; break; end
      if (m_wr) begin
        wr_hi++;
        if (m_wdata !== 16'h5A5A || m_addr !== 16'h1234 || m_rd) bad = 1'b1;
      end else begin
        bad = 1'b1;
      end
    end
    d_wr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d_done) pulses++;
    end
    checks++;
    if (n != 4 || wr_hi != 3) begin
      failures++; $display("FAIL write_timing: done at %0d wr_hi %0d expected 4 and 3", n, wr_hi);
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL write_bus_hold: bad cycle got 1 expected 0");
    end
    checks++;
    if (pulses != 1) begin
      failures++; $display("FAIL write_done_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (!sim_mem.exists(16'h1234) || sim_mem[16'h1234] !== 16'h5A5A) begin
      failures++; $display("FAIL write_mem_value: memory did not receive 5a5a");
    end
    checks++;
    if (d_rdata !== exp_d_rdata) begin
      failures++; $display("FAIL write_rdata_hold: got %h expected %h", d_rdata, exp_d_rdata);
    end
    ref_mem[16'h1234] = 16'h5A5A;
  endtask

  task automatic test_contention();
    logic [0:0] got[$];
    int streak;
    bit timeout;
    exp_q.delete();
    streak = 0;
    // Both sides always requesting: data until the streak limit, then one fetch.
    for (int k = 0; k < 6; k++) begin
      if (streak < MAX_STREAK) begin exp_q.push_back(1'b0); streak++; end
      else begin exp_q.push_back(1'b1); streak = 0; end
    end
    resp_en = 1'b1; resp_rand = 1'b1;
    i_addr = 16'h0010; i_rd = 1'b1;
    d_addr = 16'h8000; d_rd = 1'b1;
    timeout = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (i_done) begin
        got.push_back(1'b1);
        checks++;
        if (i_data !== init_val(16'h0010)) begin
          failures++; $display("FAIL contention_i_data: got %h expected %h", i_data, init_val(16'h0010));
        end
      end
      if (d_done) begin
        got.push_back(1'b0);
        checks++;
        if (d_rdata !== ref_lookup(16'h8000)) begin
          failures++; $display("FAIL contention_d_rdata: got %h expected %h", d_rdata, ref_lookup(16'h8000));
        end
        exp_d_rdata = ref_lookup(16'h8000);
      end
      if (got.size() >= 6) begin timeout = 1'b0; break; end
    end
    i_rd = 1'b0; d_rd = 1'b0;
    checks++;
    if (timeout) begin
      failures++; $display("FAIL contention_timeout: got %0d grants expected 6", got.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got[k] !== exp_q[k]) begin
          failures++;
          $display("FAIL contention_order[%0d]: got %s expected %s", k,
                   got[k] ? "I" : "D", exp_q[k] ? "I" : "D");
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_instr(input int n_txn);
    logic [15:0] a;
    bit ok;
    int dcount;
    for (int k = 0; k < n_txn; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = 16'($urandom_range(0, 255));
      i_addr = a; i_rd = 1'b1;
      ok = 1'b0; dcount = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (d_done) dcount++;
        if (i_done) begin ok = 1'b1; break; end
      end
      i_rd = 1'b0;
      checks++;
      if (!ok) begin
        failures++; $display("FAIL rand_i_timeout: txn %0d got no i_done expected one", k);
      end else begin
        checks++;
        if (i_data !== init_val(a)) begin
          failures++; $display("FAIL rand_i_data: addr %h got %h expected %h", a, i_data, init_val(a));
        end
        checks++;
        if (dcount > MAX_STREAK + 1) begin
          failures++; $display("FAIL rand_starvation: got %0d data grants expected <= %0d", dcount, MAX_STREAK + 1);
        end
      end
    end
  endtask

  task automatic drive_data(input int n_txn);
    logic [15:0] a;
    logic [15:0] wd;
    bit is_wr;
    bit ok;
    for (int k = 0; k < n_txn; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = 16'h8000 | 16'($urandom_range(0, 15));
      wd = 16'($urandom);
      is_wr = 1'($urandom_range(0, 1));
      d_addr = a; d_wdata = wd; d_rd = ~is_wr; d_wr = is_wr;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (d_done) begin ok = 1'b1; break; end
      end
      d_rd = 1'b0; d_wr = 1'b0;
      checks++;
      if (!ok) begin
        failures++; $display("FAIL rand_d_timeout: txn %0d got no d_done expected one", k);
      end else if (is_wr) begin
        ref_mem[a] = wd;
        checks++;
        if (d_rdata !== exp_d_rdata) begin
          failures++; $display("FAIL rand_d_write_hold: got %h expected %h", d_rdata, exp_d_rdata);
        end
      end else begin
        checks++;
        if (d_rdata !== ref_lookup(a)) begin
          failures++; $display("FAIL rand_d_read: addr %h got %h expected %h", a, d_rdata, ref_lookup(a));
        end
        exp_d_rdata = ref_lookup(a);
      end
    end
  endtask

  task automatic test_back_to_back();
    resp_en = 1'b1; resp_rand = 1'b1;
    fork
      drive_instr(30);
      drive_data(30);
    join
    repeat (2) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL rand_no_err: got %b expected 0", err);
    end
  endtask

  task automatic test_dual_req_err();
    bit bad;
    d_addr = 16'h8003; d_rd = 1'b1; d_wr = 1'b1;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || m_rd !== 1'b0 || m_wr !== 1'b0) begin
      failures++; $display("FAIL dual_req_err: err=%b m_rd=%b m_wr=%b expected 1 0 0", err, m_rd, m_wr);
    end
    d_rd = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0005; i_rd = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (err !== 1'b1 || m_rd || m_wr || i_done || d_done) bad = 1'b1;
    end
    i_rd = 1'b0;
    checks++;
    if (bad) begin
      failures++; $display("FAIL err_sticky: left error or strobed got 1 expected 0");
    end
    reset_dut();
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_cleared_by_rst: got %b expected 0", err);
    end
  endtask

  task automatic test_m_err();
    bit bad;
    resp_en = 1'b0;
    i_addr = 16'h0020; i_rd = 1'b1;
    @(negedge clk);
    checks++;
    if (m_rd !== 1'b1) begin
      failures++; $display("FAIL merr_grant: m_rd=%b expected 1", m_rd);
    end
    m_err = 1'b1;
    @(negedge clk);
    m_err = 1'b0;
    checks++;
    if (err !== 1'b1 || m_rd !== 1'b0) begin
      failures++; $display("FAIL merr_enter: err=%b m_rd=%b expected 1 0", err, m_rd);
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (i_done || !err) bad = 1'b1;
    end
    i_rd = 1'b0;
    checks++;
    if (bad) begin
      failures++; $display("FAIL merr_no_done: i_done seen or err lost got 1 expected 0");
    end
    reset_dut();
    resp_en = 1'b1;
  endtask

  task automatic test_async_reset();
    bit ok;
    resp_en = 1'b0;
    d_addr = 16'h8001; d_rd = 1'b1;
    @(negedge clk);
    checks++;
    if (m_rd !== 1'b1) begin
      failures++; $display("FAIL areset_grant: m_rd=%b expected 1", m_rd);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({m_rd, m_wr, d_done, err} !== 4'b0000) begin
      failures++; $display("FAIL areset_immediate: got %b expected 0000", {m_rd, m_wr, d_done, err});
    end
    d_rd = 1'b0;
    exp_d_rdata = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    resp_en = 1'b1; resp_rand = 1'b0; resp_lat = 1;
    i_addr = 16'h0041; i_rd = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (i_done) begin ok = 1'b1; break; end
    end
    i_rd = 1'b0;
    checks++;
    if (!ok || i_data !== init_val(16'h0041)) begin
      failures++; $display("FAIL areset_recover: done=%b data=%h expected 1 %h", ok, i_data, init_val(16'h0041));
    end
  endtask

  initial begin
    resp_en = 1'b1; resp_rand = 1'b0; resp_lat = 1;
    exp_d_rdata = 16'h0000;
    test_reset();
    test_instr_read();
    test_data_write();
    test_contention();
    test_back_to_back();
    test_dual_req_err();
    test_m_err();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
